mem_stage: RTL

- Memory-access stage of the 16-bit pipelined core. Sits directly downstream of the execute stage and upstream of writeback.
- Consumes the execute stage's registered outputs: ALU result, register-write control, memory-op code, destination register, address and store data.
- Owns a single-port synchronous data RAM. Performs loads and stores and registers the writeback bundle.
- Loads take two cycles because RAM read latency is 1. The stage raises a one-cycle stall to upstream for each load.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/data_ram.sv | 21 ++
 rtl/mem_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline encodings and widths for the memory stage
package pipe_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD_WAIT
  } mem_state_e;
endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port synchronous RAM, read latency 1
module data_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents are deliberately not reset; the read port samples every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: loads, stores and writeback register
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluOutput,
  input  logic              writeReg,
  input  logic [1:0]        memWrite,
  input  logic [REG_W-1:0]  regAddress,
  input  logic [15:0]       Address,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] wbData,
  output logic              wbWriteReg,
  output logic [REG_W-1:0]  wbRegAddress,
  output logic              stall
);
  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_write_q, wb_write_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic              pend_write_q, pend_write_d;
  logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_hi;

  // Upper address bits are ignored so addresses wrap modulo RAM depth.
  assign unused_addr_hi = ^Address[15:ADDR_W];

  data_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (Address[ADDR_W-1:0]),
    .wdata(storeData),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    ram_we       = 1'b0;
    wb_data_d    = aluOutput;
    wb_write_d   = writeReg;
    wb_reg_d     = regAddress;
    pend_write_d = pend_write_q;
    pend_reg_d   = pend_reg_q;
    case (state_q)
      ST_IDLE: begin
        case (memWrite)
          MEM_LOAD: begin
            stall        = 1'b1;
            state_d      = ST_LOAD_WAIT;
            wb_data_d    = '0;
            wb_write_d   = 1'b0;
            wb_reg_d     = '0;
            pend_write_d = writeReg;
            pend_reg_d   = regAddress;
          end
          MEM_STORE: ram_we = 1'b1;
          default: ;
        endcase
      end
      ST_LOAD_WAIT: begin
        // The held load on the inputs is ignored; only the latched target counts.
        state_d    = ST_IDLE;
        wb_data_d  = ram_rdata;
        wb_write_d = pend_write_q;
        wb_reg_d   = pend_reg_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      stall  = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wb_data_q    <= '0;
      wb_write_q   <= 1'b0;
      wb_reg_q     <= '0;
      pend_write_q <= 1'b0;
      pend_reg_q   <= '0;
    end else begin
      state_q      <= state_d;
      wb_data_q    <= wb_data_d;
      wb_write_q   <= wb_write_d;
      wb_reg_q     <= wb_reg_d;
      pend_write_q <= pend_write_d;
      pend_reg_q   <= pend_reg_d;
    end
  end

  assign wbData       = wb_data_q;
  assign wbWriteReg   = wb_write_q;
  assign wbRegAddress = wb_reg_q;
endmodule
